mem_bram_responder: RTL

Memory-side responder for the command/write/read FIFO protocol issued by the core FIFO arbiter. Accepts one memory command at a time, then sinks write words into, or sources read words from, an on-chip block RAM. Used as the memory endpoint in simulation and in DDR-less builds, so the arbiter and its async FIFOs run unchanged against internal storage.

---
 rtl/mem_bram_responder_pkg.sv | 26 ++
 rtl/mem_bram_responder_bram_sp.sv | 25 ++
 rtl/mem_bram_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_bram_responder_pkg.sv
// rtl/mem_bram_responder_pkg.sv - memory command layout and responder state encoding
package mem_bram_responder_pkg;

   localparam int CMD_WIDTH      = 65;
   localparam int CMD_ADDR_WIDTH = 32;
   localparam int CMD_LEN_WIDTH  = 32;

   // Command word as issued by the core FIFO arbiter, MSB first.
   typedef struct packed {
      logic                      read_not_write;
      logic [CMD_ADDR_WIDTH-1:0] address;
      logic [CMD_LEN_WIDTH-1:0]  length;
   } memory_command_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } resp_state_t;

   // True when the word about to complete is the final one of the burst.
   function automatic logic is_last_word(input logic [CMD_LEN_WIDTH-1:0] left);
      return left == CMD_LEN_WIDTH'(1);
   endfunction

endpackage

// File: rtl/mem_bram_responder_bram_sp.sv
// rtl/mem_bram_responder_bram_sp.sv - single-port block RAM, write-first, registered read
module bram_sp #(
   parameter int mem_width  = 32,
   parameter int addr_width = 10
) (
   input  logic                  clk_core,
   input  logic                  we,
   input  logic [addr_width-1:0] addr,
   input  logic [mem_width-1:0]  wdata,
   output logic [mem_width-1:0]  rdata
);

   logic [mem_width-1:0] mem [1 << addr_width];

   // Storage is never cleared; a write also returns the new word on rdata.
   always_ff @(posedge clk_core) begin
      if (we) begin
         mem[addr] <= wdata;
         rdata     <= wdata;
      end else begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_bram_responder.sv
// rtl/mem_bram_responder.sv - memory endpoint serving arbiter commands from on-chip RAM
module mem_bram_responder #(
   parameter int mem_width     = 32,
   parameter int addr_width    = 10,
   parameter int buf_log_depth = 2
) (
   input  logic                 clk_core,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [64:0]          cmd_data,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [mem_width-1:0] wr_data,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic [mem_width-1:0] rd_data,
   output logic                 busy,
   output logic [31:0]          cmd_count,
   output logic [31:0]          words_written,
   output logic [31:0]          words_read
);

   import mem_bram_responder_pkg::*;

   localparam int BUF_DEPTH = 1 << buf_log_depth;
   // Leave room for the word in flight plus the one issued this cycle.
   localparam logic [buf_log_depth:0] ISSUE_LIMIT = (buf_log_depth + 1)'(BUF_DEPTH - 2);

   memory_command_t           cmd;
   resp_state_t               state;
   logic [addr_width-1:0]     ram_addr;
   logic [31:0]               xfer_left;   // words still to accept (write) or to hand out (read)
   logic [31:0]               issue_left;  // RAM reads not yet issued
   logic                      inflight;
   logic [mem_width-1:0]      ram_rdata;
   logic                      ram_we;

   logic [mem_width-1:0]      fifo_mem [BUF_DEPTH];
   logic [buf_log_depth-1:0]  buf_wr_ptr;
   logic [buf_log_depth-1:0]  buf_rd_ptr;
   logic [buf_log_depth:0]    buf_count;
   logic [buf_log_depth:0]    occupancy;

   logic                      cmd_fire;
   logic                      wr_fire;
   logic                      rd_fire;
   logic                      issue;
   logic                      push;
   logic                      unused_cmd_bits;

   assign cmd             = cmd_data;
   assign unused_cmd_bits = ^cmd.address[CMD_ADDR_WIDTH-1:addr_width];

   assign cmd_ready = !reset && (state == ST_IDLE);
   assign wr_ready  = !reset && (state == ST_WRITE);
   assign busy      = (state != ST_IDLE);

   assign cmd_fire = cmd_valid && cmd_ready;
   assign wr_fire  = wr_valid && wr_ready;
   assign rd_fire  = rd_valid && rd_ready;

   assign occupancy = buf_count + {{buf_log_depth{1'b0}}, inflight};
   assign issue     = (state == ST_READ) && (issue_left != 32'd0) && (occupancy <= ISSUE_LIMIT);
   assign push      = inflight;
   assign ram_we    = wr_fire;

   assign rd_valid = (buf_count != '0);
   assign rd_data  = rd_valid ? fifo_mem[buf_rd_ptr] : '0;

   bram_sp #(
      .mem_width  (mem_width),
      .addr_width (addr_width)
   ) u_bram (
      .clk_core (clk_core),
      .we       (ram_we),
      .addr     (ram_addr),
      .wdata    (wr_data),
      .rdata    (ram_rdata)
   );

   // Command FSM: latch a command, step the RAM address per word, return to IDLE when done.
   always_ff @(posedge clk_core) begin
      if (reset) begin
         state      <= ST_IDLE;
         ram_addr   <= '0;
         xfer_left  <= '0;
         issue_left <= '0;
         inflight   <= 1'b0;
      end else begin
         inflight <= issue;
         unique case (state)
            ST_IDLE: begin
               if (cmd_fire) begin
                  ram_addr   <= cmd.address[addr_width-1:0];
                  xfer_left  <= cmd.length;
                  issue_left <= cmd.length;
                  // A zero-length command is consumed without leaving IDLE.
                  if (cmd.length != '0) begin
                     state <= cmd.read_not_write ? ST_READ : ST_WRITE;
                  end
               end
            end
            ST_WRITE: begin
               if (wr_fire) begin
                  ram_addr  <= ram_addr + addr_width'(1);
                  xfer_left <= xfer_left - 32'd1;
                  if (is_last_word(xfer_left)) begin
                     state <= ST_IDLE;
                  end
               end
            end
            ST_READ: begin
               if (issue) begin
                  ram_addr   <= ram_addr + addr_width'(1);
                  issue_left <= issue_left - 32'd1;
               end
               // The last pop implies every issued read has already landed in the buffer.
               if (rd_fire) begin
                  xfer_left <= xfer_left - 32'd1;
                  if (is_last_word(xfer_left)) begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Output buffer storage: capture RAM data the cycle after each issued read.
   always_ff @(posedge clk_core) begin
      if (push) begin
         fifo_mem[buf_wr_ptr] <= ram_rdata;
      end
   end

   // Output buffer pointers and occupancy; push and pop together leave the count unchanged.
   always_ff @(posedge clk_core) begin
      if (reset) begin
         buf_wr_ptr <= '0;
         buf_rd_ptr <= '0;
         buf_count  <= '0;
      end else begin
         if (push) begin
            buf_wr_ptr <= buf_wr_ptr + buf_log_depth'(1);
         end
         if (rd_fire) begin
            buf_rd_ptr <= buf_rd_ptr + buf_log_depth'(1);
         end
         unique case ({push, rd_fire})
            2'b10:   buf_count <= buf_count + (buf_log_depth + 1)'(1);
            2'b01:   buf_count <= buf_count - (buf_log_depth + 1)'(1);
            default: buf_count <= buf_count;
         endcase
      end
   end

   // Activity counters, free-running and wrapping.
   always_ff @(posedge clk_core) begin
      if (reset) begin
         cmd_count     <= '0;
         words_written <= '0;
         words_read    <= '0;
      end else begin
         if (cmd_fire) cmd_count     <= cmd_count + 32'd1;
         if (wr_fire)  words_written <= words_written + 32'd1;
         if (rd_fire)  words_read    <= words_read + 32'd1;
      end
   end

endmodule
